// File: rtl/conv_3x3_host_if.sv
// conv_3x3_host_if: input byte stream and result byte stream of conv_3x3_host
interface conv_3x3_host_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/conv_3x3_host.sv
// conv_3x3_host: streams 25 bytes into the conv_3x3 engine, starts it and streams the 2x2 result back
module conv_3x3_host #(
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_3x3_host_if.slave       bus,
  output logic                 conv_start,
  output logic [71:0]          w_flat,
  output logic [127:0]         in_flat,
  input  logic [7:0]           conv_out_11,
  input  logic [7:0]           conv_out_12,
  input  logic [7:0]           conv_out_21,
  input  logic [7:0]           conv_out_22,
  input  logic                 conv_done,
  output logic                 err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;
  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [71:0]    w_q, w_d;
  logic [127:0]   px_q, px_d;
  logic [31:0]    res_q, res_d;
  logic           err_q, err_d;
  logic           start_q, start_d;
  logic           mv_q, mv_d;
  logic           s_acc, m_acc;
  assign bus.s_ready = rst_n && state_q == LOAD;
  assign bus.m_valid = mv_q;
  assign bus.m_data  = res_q[8*idx_q +: 8];
  assign bus.m_last  = mv_q && idx_q == 2'd3;
  assign conv_start  = start_q;
  assign w_flat      = w_q;
  assign in_flat     = px_q;
  assign err         = err_q;
  always_comb begin
    s_acc   = bus.s_valid && bus.s_ready;
    m_acc   = mv_q && bus.m_ready;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    w_d     = w_q;
    px_d    = px_q;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    mv_d    = mv_q;
    case (state_q)
      LOAD: if (s_acc) begin
        for (int k = 0; k < 9; k++) if (cnt_q == 5'(k)) w_d[8*k +: 8] = bus.s_data;
        for (int k = 0; k < 16; k++) if (cnt_q == 5'(k + 9)) px_d[8*k +: 8] = bus.s_data;
        cnt_d   = cnt_q == 5'd24 ? 5'd0 : cnt_q + 5'd1;
        state_d = cnt_q == 5'd24 ? START : LOAD;
        start_d = cnt_q == 5'd24;
      end
      START: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      // engine clears its outputs after done, so results are grabbed in the done cycle itself
      WAIT: if (conv_done) begin
        res_d   = {conv_out_22, conv_out_21, conv_out_12, conv_out_11};
        state_d = SEND;
        mv_d    = 1'b1;
      end else if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        state_d = LOAD;
      end else begin
        tmo_d   = tmo_q + 1'b1;
      end
      SEND: if (m_acc) begin
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? LOAD : SEND;
        mv_d    = idx_q != 2'd3;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      w_q     <= '0;
      px_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      w_q     <= w_d;
      px_q    <= px_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
      mv_q    <= mv_d;
    end
endmodule
